reg_dump_reader: RTL and testbench



---
 rtl/riscv_pkg.sv | 14 +
 rtl/stream_out_reg.sv | 47 ++++
 rtl/reg_dump_reader.sv | 114 +++++++++++
 tb/tb_reg_dump_reader.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared register-file constants and the dump reader's state encoding.
package riscv_pkg;

  localparam int RF_NUM_REGS = 32;
  localparam int RF_ADDR_W   = 5;
  localparam int XLEN        = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } dump_state_e;

endpackage

// File: rtl/stream_out_reg.sv
// Single-entry valid/ready holding register. The payload stays frozen while
// valid is high and the consumer is not ready.
module stream_out_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] dout,
  output logic             load_ok
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q,  data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      data_d  = din;
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid   = valid_q;
  assign dout    = data_q;
  assign load_ok = !valid_q || ready;

endmodule

// File: rtl/reg_dump_reader.sv
// Walks the register file x0..x(NUM_REGS-1) through a spare async read port
// and streams each word with its index and a last flag over valid/ready.
module reg_dump_reader
  import riscv_pkg::*;
#(
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int DATA_W   = XLEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_idx,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int PW = DATA_W + ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

  dump_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic              done_q,  done_d;

  logic              load;
  logic              load_ok;
  logic [PW-1:0]     payload_in;
  logic [PW-1:0]     payload_out;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    done_d  = 1'b0;
    load    = 1'b0;
    if (abort) begin
      state_d = IDLE;
      addr_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            addr_d  = '0;
            state_d = SCAN;
          end
        end
        SCAN: begin
          if (load_ok) begin
            load = 1'b1;
            // The last index parks the counter so it never wraps past NUM_REGS-1.
            if (addr_q == LAST_ADDR) begin
              state_d = DRAIN;
            end else begin
              addr_d = addr_q + ADDR_W'(1);
            end
          end
        end
        DRAIN: begin
          if (out_valid && out_ready) begin
            done_d  = 1'b1;
            state_d = IDLE;
            addr_d  = '0;
          end
        end
        default: begin
          state_d = IDLE;
          addr_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
    end
  end

  assign payload_in = {rd_data, addr_q, (addr_q == LAST_ADDR)};

  stream_out_reg #(
    .WIDTH (PW)
  ) u_out (
    .clk     (clk),
    .rst     (rst),
    .flush   (abort),
    .load    (load),
    .din     (payload_in),
    .ready   (out_ready),
    .valid   (out_valid),
    .dout    (payload_out),
    .load_ok (load_ok)
  );

  assign out_data = payload_out[PW-1 -: DATA_W];
  assign out_idx  = payload_out[ADDR_W:1];
  assign out_last = payload_out[0];
  assign rd_addr  = addr_q;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Directed bench for reg_dump_reader: full dump, backpressure, ignored start,
// abort, reset in DRAIN, and a two-register configuration.
module tb_reg_dump_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, abort, out_ready;
  logic [4:0]  rd_addr, out_idx;
  logic [31:0] rd_data, out_data;
  logic        out_valid, out_last, busy, done;

  logic        s2_start, s2_abort, s2_ready;
  logic [4:0]  s2_rd_addr, s2_idx;
  logic [31:0] s2_rd_data, s2_data;
  logic        s2_valid, s2_last, s2_busy, s2_done;

  logic [31:0] rf [0:31];
  int checks   = 0;
  int failures = 0;

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 32'h0 : 32'hA5A50000 + 32'(i);
  end

  assign rd_data    = rf[rd_addr];
  assign s2_rd_data = rf[s2_rd_addr];

  reg_dump_reader #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .busy(busy), .done(done)
  );

  reg_dump_reader #(.NUM_REGS(2), .ADDR_W(5), .DATA_W(32)) dut2 (
    .clk(clk), .rst(rst), .start(s2_start), .abort(s2_abort),
    .rd_addr(s2_rd_addr), .rd_data(s2_rd_data),
    .out_valid(s2_valid), .out_ready(s2_ready), .out_data(s2_data),
    .out_idx(s2_idx), .out_last(s2_last), .busy(s2_busy), .done(s2_done)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rf_val(input int i);
    return (i == 0) ? 32'h0 : 32'hA5A50000 + 32'(i);
  endfunction

  // toggle=0: out_ready held high, cycle-exact checks; toggle=1: ready pattern 1,0,0,1.
  task automatic run_dump(input int restart_cyc, input bit toggle);
    int          exp_idx  = 0;
    int          done_cnt = 0;
    int          done_cyc = -1;
    bit          held     = 1'b0;
    bit          rdy;
    logic [31:0] hd = '0;
    logic [4:0]  hi = '0;
    @(negedge clk);
    check_eq("idle_busy", 64'(busy), 64'(0));
    start = 1'b1;
    abort = 1'b0;
    out_ready = 1'b1;
    for (int cyc = 1; cyc < 400; cyc++) begin
      @(negedge clk);
      start = (cyc == restart_cyc);
      rdy = toggle ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      out_ready = rdy;
      if (!toggle) begin
        check_eq("busy", 64'(busy), 64'(cyc >= 1 && cyc <= 33));
        check_eq("valid", 64'(out_valid), 64'(cyc >= 2 && cyc <= 33));
        check_eq("done", 64'(done), 64'(cyc == 34));
      end
      if (held) begin
        check_eq("stall_valid", 64'(out_valid), 64'(1));
        check_eq("stall_idx", 64'(out_idx), 64'(hi));
        check_eq("stall_data", 64'(out_data), 64'(hd));
      end
      held = 1'b0;
      if (out_valid) begin
        if (rdy) begin
          check_eq("word_idx", 64'(out_idx), 64'(exp_idx));
          check_eq("word_data", 64'(out_data), 64'(rf_val(exp_idx)));
          check_eq("word_last", 64'(out_last), 64'(exp_idx == 31));
          $display("word idx=%0d data=0x%08h last=%0b cyc=%0d", out_idx, out_data, out_last, cyc);
          exp_idx++;
        end else begin
          held = 1'b1;
          hi   = out_idx;
          hd   = out_data;
        end
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
    end
    start = 1'b0;
    check_eq("word_count", 64'(exp_idx), 64'(32));
    check_eq("done_count", 64'(done_cnt), 64'(1));
    if (!toggle) check_eq("done_cycle", 64'(done_cyc), 64'(34));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    s2_start = 1'b0; s2_abort = 1'b0; s2_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_valid", 64'(out_valid), 64'(0));
    check_eq("rst_data", 64'(out_data), 64'(0));
    check_eq("rst_idx", 64'(out_idx), 64'(0));
    check_eq("rst_last", 64'(out_last), 64'(0));
    check_eq("rst_busy", 64'(busy), 64'(0));
    check_eq("rst_done", 64'(done), 64'(0));
    check_eq("rst_addr", 64'(rd_addr), 64'(0));
    check_eq("rst_s2_valid", 64'(s2_valid), 64'(0));
    rst = 1'b0;

    $display("test full dump");
    run_dump(-1, 1'b0);
    $display("test ignored start");
    run_dump(10, 1'b0);
    $display("test backpressure");
    run_dump(-1, 1'b1);

    $display("test abort");
    @(negedge clk);
    start = 1'b1; out_ready = 1'b1;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (cyc == 12) begin
        check_eq("abort_pre_valid", 64'(out_valid), 64'(1));
        check_eq("abort_pre_idx", 64'(out_idx), 64'(10));
        out_ready = 1'b0;
        abort = 1'b1;
      end
    end
    @(negedge clk);
    abort = 1'b0;
    check_eq("abort_valid", 64'(out_valid), 64'(0));
    check_eq("abort_busy", 64'(busy), 64'(0));
    check_eq("abort_addr", 64'(rd_addr), 64'(0));
    check_eq("abort_done", 64'(done), 64'(0));
    repeat (3) begin
      @(negedge clk);
      check_eq("abort_no_done", 64'(done), 64'(0));
      check_eq("abort_idle", 64'(busy), 64'(0));
    end
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check_eq("abort_start_busy", 64'(busy), 64'(0));
    check_eq("abort_start_valid", 64'(out_valid), 64'(0));
    run_dump(-1, 1'b0);

    $display("test reset in drain");
    @(negedge clk);
    start = 1'b1; out_ready = 1'b1;
    for (int cyc = 1; cyc <= 33; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (cyc == 33) out_ready = 1'b0;
    end
    @(negedge clk);
    check_eq("drain_busy", 64'(busy), 64'(1));
    check_eq("drain_valid", 64'(out_valid), 64'(1));
    check_eq("drain_idx", 64'(out_idx), 64'(31));
    check_eq("drain_last", 64'(out_last), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("mrst_valid", 64'(out_valid), 64'(0));
    check_eq("mrst_data", 64'(out_data), 64'(0));
    check_eq("mrst_idx", 64'(out_idx), 64'(0));
    check_eq("mrst_last", 64'(out_last), 64'(0));
    check_eq("mrst_busy", 64'(busy), 64'(0));
    check_eq("mrst_done", 64'(done), 64'(0));
    check_eq("mrst_addr", 64'(rd_addr), 64'(0));
    repeat (3) begin
      @(negedge clk);
      check_eq("mrst_no_done", 64'(done), 64'(0));
    end
    out_ready = 1'b1;

    $display("test two-register config");
    @(negedge clk);
    s2_start = 1'b1; s2_ready = 1'b0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      s2_start = 1'b0;
      s2_ready = (cyc >= 7);
      check_eq("s2_addr_range", 64'(s2_rd_addr <= 5'd1), 64'(1));
      check_eq("s2_busy", 64'(s2_busy), 64'(cyc >= 1 && cyc <= 8));
      check_eq("s2_valid", 64'(s2_valid), 64'(cyc >= 2 && cyc <= 8));
      check_eq("s2_done", 64'(s2_done), 64'(cyc == 9));
      if (cyc >= 2 && cyc <= 7) begin
        check_eq("s2_idx0", 64'(s2_idx), 64'(0));
        check_eq("s2_last0", 64'(s2_last), 64'(0));
        check_eq("s2_data0", 64'(s2_data), 64'(0));
      end
      if (cyc == 8) begin
        check_eq("s2_idx1", 64'(s2_idx), 64'(1));
        check_eq("s2_last1", 64'(s2_last), 64'(1));
        check_eq("s2_data1", 64'(s2_data), 64'(32'hA5A50001));
      end
      if (s2_valid && s2_ready)
        $display("s2 word idx=%0d data=0x%08h last=%0b cyc=%0d", s2_idx, s2_data, s2_last, cyc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
